// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result select, load codes, FSM states.
package wb_pkg;

  // Result source select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Holding register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load data alignment/extension and misalignment detection.
module load_extend
  import wb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half, then extend according to funct3
  always_comb begin
    byte_sel   = word_i[7:0];
    half_sel   = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    data_o     = 32'h0;
    misalign_o = 1'b0;
    case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    case (funct3_i)
      F3_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data_o = {24'h0, byte_sel};
      F3_LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o     = {16'h0, half_sel};
        misalign_o = addr_lo_i[0];
      end
      F3_LW: begin
        data_o     = word_i;
        misalign_o = (addr_lo_i != 2'd0);
      end
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Single-entry writeback holding register: result mux, RF write, bypass, retire count.
module writeback_unit
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lo,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_load_word,
  input  logic [31:0] mem_pc_plus4,
  input  logic [31:0] mem_imm,
  input  logic        wb_stall,
  output logic        RegWrite,
  output logic [4:0]  Rd,
  output logic [31:0] Write_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        retire,
  output logic        misalign_err,
  output logic [63:0] instret
);

  wb_state_e   state_q, state_d;
  logic        regw_q;
  logic        mis_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic [63:0] instret_q;

  logic [31:0] ld_data;
  logic        ld_mis;
  logic [31:0] result;
  logic        accept;
  logic        full;
  logic        wr_ok;

  load_extend u_ld (
    .funct3_i   (mem_funct3),
    .addr_lo_i  (mem_addr_lo),
    .word_i     (mem_load_word),
    .data_o     (ld_data),
    .misalign_o (ld_mis)
  );

  // Result source mux for the incoming instruction
  always_comb begin
    result = mem_alu_result;
    case (mem_wb_sel)
      WB_ALU:  result = mem_alu_result;
      WB_LOAD: result = ld_data;
      WB_PC4:  result = mem_pc_plus4;
      WB_IMM:  result = mem_imm;
      default: result = mem_alu_result;
    endcase
  end

  // Next-state and handshake/output control
  always_comb begin
    state_d   = state_q;
    full      = (state_q == ST_FULL);
    mem_ready = !full || !wb_stall;
    accept    = mem_valid && mem_ready;
    retire    = full && !wb_stall;
    wr_ok     = full && regw_q && (rd_q != 5'd0) && !mis_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!wb_stall) state_d = accept ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Holding register: captured only on accept, so contents hold across stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regw_q <= 1'b0;
      mis_q  <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= 32'h0;
    end else if (accept) begin
      regw_q <= mem_reg_write;
      mis_q  <= (mem_wb_sel == WB_LOAD) && ld_mis;
      rd_q   <= mem_rd;
      data_q <= result;
    end
  end

  // Retired-instruction counter, wraps naturally at 64 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= 64'd0;
    else if (retire) instret_q <= instret_q + 64'd1;
  end

  assign RegWrite     = wr_ok && !wb_stall;
  assign fwd_valid    = wr_ok;
  assign Rd           = rd_q;
  assign Write_data   = data_q;
  assign fwd_rd       = rd_q;
  assign fwd_data     = data_q;
  assign misalign_err = retire && mis_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with hand-computed expectations.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic [1:0]  mem_wb_sel = 2'b00;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [1:0]  mem_addr_lo = 2'b00;
  logic [31:0] mem_alu_result = 32'h0;
  logic [31:0] mem_load_word = 32'h0;
  logic [31:0] mem_pc_plus4 = 32'h0;
  logic [31:0] mem_imm = 32'h0;
  logic        wb_stall = 1'b0;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        retire;
  logic        misalign_err;
  logic [63:0] instret;

  int passed = 0;
  int total  = 0;

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
    .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
    .wb_stall(wb_stall),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire(retire), .misalign_err(misalign_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] lo);
    mem_valid     = 1'b1;
    mem_reg_write = rw;
    mem_rd        = rd;
    mem_wb_sel    = sel;
    mem_funct3    = f3;
    mem_addr_lo   = lo;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rd", Rd, 0);
    chk("rst_wdata", Write_data, 0);
    chk("rst_instret", instret, 0);
    chk("rst_ready", mem_ready, 1);
    chk("rst_retire", retire, 0);
    rst_n = 1'b1;
    tick();

    // ALU write
    drive(1, 5'd5, 2'b00, 3'b000, 2'd0);
    mem_alu_result = 32'h0000_00AA;
    tick();
    mem_valid = 1'b0;
    chk("alu_regwrite", RegWrite, 1);
    chk("alu_rd", Rd, 5);
    chk("alu_wdata", Write_data, 32'hAA);
    chk("alu_retire", retire, 1);
    chk("alu_fwd_valid", fwd_valid, 1);
    chk("alu_fwd_data", fwd_data, 32'hAA);
    tick();
    chk("alu_instret", instret, 1);
    chk("alu_drain_regwrite", RegWrite, 0);

    // Loads, issued back-to-back
    mem_load_word = 32'h80FF_7F01;
    drive(1, 5'd6, 2'b01, 3'b000, 2'd3);
    tick();
    chk("lb_wdata", Write_data, 32'hFFFF_FF80);
    drive(1, 5'd6, 2'b01, 3'b101, 2'd2);
    tick();
    chk("lhu_wdata", Write_data, 32'h0000_80FF);
    chk("lhu_regwrite", RegWrite, 1);
    chk("lhu_instret", instret, 2);
    drive(1, 5'd6, 2'b01, 3'b001, 2'd2);
    tick();
    chk("lh_wdata", Write_data, 32'hFFFF_80FF);
    chk("lh_instret", instret, 3);
    mem_valid = 1'b0;
    tick();
    chk("load_instret", instret, 4);

    // Register 0 destination
    mem_pc_plus4 = 32'h0000_0104;
    drive(1, 5'd0, 2'b10, 3'b000, 2'd0);
    tick();
    mem_valid = 1'b0;
    chk("r0_regwrite", RegWrite, 0);
    chk("r0_retire", retire, 1);
    chk("r0_fwd_valid", fwd_valid, 0);
    chk("r0_wdata", Write_data, 32'h104);
    tick();
    chk("r0_instret", instret, 5);

    // Misaligned LW
    drive(1, 5'd7, 2'b01, 3'b010, 2'd1);
    tick();
    mem_valid = 1'b0;
    chk("mis_regwrite", RegWrite, 0);
    chk("mis_err", misalign_err, 1);
    chk("mis_fwd_valid", fwd_valid, 0);
    chk("mis_retire", retire, 1);
    tick();
    chk("mis_err_clear", misalign_err, 0);
    chk("mis_instret", instret, 6);

    // Undefined funct3 yields zero but still writes
    drive(1, 5'd8, 2'b01, 3'b011, 2'd0);
    tick();
    mem_valid = 1'b0;
    chk("f3bad_wdata", Write_data, 0);
    chk("f3bad_regwrite", RegWrite, 1);
    tick();
    chk("f3bad_instret", instret, 7);

    // Stall for 3 cycles while FULL; a waiting instruction must not be taken
    mem_alu_result = 32'h1234_5678;
    drive(1, 5'd9, 2'b00, 3'b000, 2'd0);
    tick();
    wb_stall = 1'b1;
    mem_rd = 5'd10;
    mem_alu_result = 32'h0000_DEAD;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", mem_ready, 0);
      chk("stall_regwrite", RegWrite, 0);
      chk("stall_fwd_valid", fwd_valid, 1);
      chk("stall_rd", Rd, 9);
      chk("stall_wdata", Write_data, 32'h1234_5678);
      chk("stall_retire", retire, 0);
      chk("stall_instret", instret, 7);
      tick();
    end
    wb_stall = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("release_regwrite", RegWrite, 1);
    chk("release_retire", retire, 1);
    chk("release_rd", Rd, 9);
    tick();
    chk("release_single_regwrite", RegWrite, 0);
    chk("release_single_retire", retire, 0);
    chk("release_instret", instret, 8);

    // Reset asserted mid-stall
    mem_alu_result = 32'h0000_0033;
    drive(1, 5'd3, 2'b00, 3'b000, 2'd0);
    tick();
    mem_valid = 1'b0;
    wb_stall = 1'b1;
    #1;
    chk("prerst_fwd_valid", fwd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_regwrite", RegWrite, 0);
    chk("midrst_fwd_valid", fwd_valid, 0);
    chk("midrst_rd", Rd, 0);
    chk("midrst_wdata", Write_data, 0);
    chk("midrst_instret", instret, 0);
    chk("midrst_retire", retire, 0);
    tick();
    rst_n = 1'b1;
    wb_stall = 1'b0;
    tick();
    chk("postrst_regwrite", RegWrite, 0);
    chk("postrst_retire", retire, 0);
    tick();
    chk("postrst_instret", instret, 0);
    chk("postrst_ready", mem_ready, 1);

    // Four back-to-back accepts
    for (int i = 1; i <= 4; i++) begin
      mem_alu_result = 32'(i * 16);
      drive(1, 5'(i), 2'b00, 3'b000, 2'd0);
      tick();
      chk("b2b_regwrite", RegWrite, 1);
      chk("b2b_rd", Rd, 64'(i));
      chk("b2b_wdata", Write_data, 64'(i * 16));
      chk("b2b_instret", instret, 64'(i - 1));
    end
    mem_valid = 1'b0;
    tick();
    chk("b2b_final_instret", instret, 4);
    chk("b2b_final_regwrite", RegWrite, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
